// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel/line counters, sync and active-draw flags,
// new-frame strobe, frame counter and fixed-delay copies of the syncs.
module video_sig_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int ACTIVE_V = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int FPS      = 60,
    parameter int DELAY    = 4
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out,
    output logic        hs_dly_out,
    output logic        vs_dly_out,
    output logic        ad_dly_out
);

    localparam int TOTAL_H = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
    localparam int TOTAL_V = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        ad_q, ad_d;
    logic        nf_q, nf_d;
    logic [5:0]  fc_q, fc_d;

    // Flags decode the *next* counter values so they line up with the counts.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == 11'(TOTAL_H - 1)) begin
            hcount_d = '0;
            vcount_d = (vcount_q == 10'(TOTAL_V - 1)) ? '0 : vcount_q + 10'd1;
        end
        ad_d = (hcount_d < 11'(ACTIVE_H)) && (vcount_d < 10'(ACTIVE_V));
        hs_d = (hcount_d >= 11'(ACTIVE_H + H_FRONT)) &&
               (hcount_d <  11'(ACTIVE_H + H_FRONT + H_SYNC));
        vs_d = (vcount_d >= 10'(ACTIVE_V + V_FRONT)) &&
               (vcount_d <  10'(ACTIVE_V + V_FRONT + V_SYNC));
        nf_d = (hcount_d == 11'(ACTIVE_H)) && (vcount_d == 10'(ACTIVE_V));
        fc_d = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == 6'(FPS - 1)) ? '0 : fc_q + 6'd1;
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_q <= 11'(TOTAL_H - 1);
            vcount_q <= 10'(TOTAL_V - 1);
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hs_out     = hs_q;
    assign vs_out     = vs_q;
    assign ad_out     = ad_q;
    assign nf_out     = nf_q;
    assign fc_out     = fc_q;

    generate
        if (DELAY == 0) begin : g_no_delay
            assign hs_dly_out = hs_q;
            assign vs_dly_out = vs_q;
            assign ad_dly_out = ad_q;
        end else begin : g_delay
            // Each stage holds {hs, vs, ad}; the last stage is DELAY cycles old.
            logic [DELAY-1:0][2:0] pipe_q, pipe_d;

            always_comb begin
                pipe_d    = pipe_q;
                pipe_d[0] = {hs_q, vs_q, ad_q};
                for (int i = 1; i < DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign {hs_dly_out, vs_dly_out, ad_dly_out} = pipe_q[DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench: a default-timing instance (DELAY=4) for line behaviour and a
// tiny-timing instance (DELAY=0) for frame wrap, vsync, new-frame and frame count.
module tb_video_sig_gen;

    localparam int TH = 1650;
    localparam int TV = 750;
    // Small instance: 8+2+3+2 = 15 pixels/line, 4+1+2+1 = 8 lines/frame
    localparam int BH = 15;
    localparam int BV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] a_h, b_h;
    logic [9:0]  a_v, b_v;
    logic        a_hs, a_vs, a_ad, a_nf, a_hsd, a_vsd, a_add;
    logic        b_hs, b_vs, b_ad, b_nf, b_hsd, b_vsd, b_add;
    logic [5:0]  a_fc, b_fc;

    video_sig_gen dut_a (
        .pixel_clk_in(clk), .rst_n_in(rst_n),
        .hcount_out(a_h), .vcount_out(a_v),
        .hs_out(a_hs), .vs_out(a_vs), .ad_out(a_ad), .nf_out(a_nf), .fc_out(a_fc),
        .hs_dly_out(a_hsd), .vs_dly_out(a_vsd), .ad_dly_out(a_add)
    );

    video_sig_gen #(
        .ACTIVE_H(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .ACTIVE_V(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .FPS(3), .DELAY(0)
    ) dut_b (
        .pixel_clk_in(clk), .rst_n_in(rst_n),
        .hcount_out(b_h), .vcount_out(b_v),
        .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc),
        .hs_dly_out(b_hsd), .vs_dly_out(b_vsd), .ad_dly_out(b_add)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected default-timing flags for the n-th cycle after release (n >= 1)
    function automatic logic a_ad_at(int n);
        int h = (n - 1) % TH;
        int v = (n - 1) / TH;
        return (n >= 1) && (h < 1280) && (v < 720);
    endfunction

    function automatic logic a_hs_at(int n);
        int h = (n - 1) % TH;
        return (n >= 1) && (h >= 1390) && (h < 1430);
    endfunction

    initial begin
        int bh, bv, bfc, bnf, hs_line0, nf_count;
        logic e_ad, e_hs, e_vs;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_a_h", 32'(a_h), 1649);
        check("rst_a_v", 32'(a_v), 749);
        check("rst_a_flags", {a_hs, a_vs, a_ad, a_nf}, 0);
        check("rst_a_fc", 32'(a_fc), 0);
        check("rst_a_dly", {a_hsd, a_vsd, a_add}, 0);
        check("rst_b_h", 32'(b_h), BH - 1);
        check("rst_b_v", 32'(b_v), BV - 1);

        rst_n = 1'b1;
        bh = BH - 1; bv = BV - 1; bfc = 0;
        hs_line0 = 0; nf_count = 0;

        for (int n = 1; n <= 3400; n++) begin
            @(negedge clk);
            // Default-timing instance
            check("a_h", 32'(a_h), 32'((n - 1) % TH));
            check("a_v", 32'(a_v), 32'((n - 1) / TH));
            check("a_ad", 32'(a_ad), 32'(a_ad_at(n)));
            check("a_hs", 32'(a_hs), 32'(a_hs_at(n)));
            check("a_vs_nf_fc", {a_vs, a_nf, a_fc}, 0);
            check("a_ad_dly", 32'(a_add), 32'(a_ad_at(n - 4)));
            check("a_hs_dly", 32'(a_hsd), 32'(a_hs_at(n - 4)));
            check("a_vs_dly", 32'(a_vsd), 0);
            if (n <= TH && a_hs) hs_line0++;

            // Tiny-timing instance
            if (bh == BH - 1) begin
                bh = 0;
                bv = (bv == BV - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
            bnf  = (bh == 8 && bv == 4) ? 1 : 0;
            if (bnf == 1) bfc = (bfc + 1) % 3;
            e_ad = (bh < 8) && (bv < 4);
            e_hs = (bh >= 10) && (bh < 13);
            e_vs = (bv >= 5) && (bv < 7);
            check("b_h", 32'(b_h), 32'(bh));
            check("b_v", 32'(b_v), 32'(bv));
            check("b_ad", 32'(b_ad), 32'(e_ad));
            check("b_hs", 32'(b_hs), 32'(e_hs));
            check("b_vs", 32'(b_vs), 32'(e_vs));
            check("b_nf", 32'(b_nf), 32'(bnf));
            check("b_fc", 32'(b_fc), 32'(bfc));
            check("b_dly", {b_hsd, b_vsd, b_add}, {e_hs, e_vs, e_ad});
            if (b_nf) nf_count++;
        end

        check("a_hs_width_line0", 32'(hs_line0), 40);
        // nf at cycle 69 + 120k for k = 0..27
        check("b_nf_count", 32'(nf_count), 28);
        check("b_fc_before_reset", 32'(b_fc), 1);

        // Asynchronous reset mid-cycle: values must change before the next edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_h", 32'(a_h), 1649);
        check("arst_a_v", 32'(a_v), 749);
        check("arst_a_flags", {a_hs, a_vs, a_ad, a_nf}, 0);
        check("arst_a_dly", {a_hsd, a_vsd, a_add}, 0);
        check("arst_b_h", 32'(b_h), BH - 1);
        check("arst_b_v", 32'(b_v), BV - 1);
        check("arst_b_fc", 32'(b_fc), 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_a_hv", {21'(a_h), 11'(a_v)}, 0);
        check("restart_a_ad", 32'(a_ad), 1);
        check("restart_a_fc", 32'(a_fc), 0);
        check("restart_a_add", 32'(a_add), 0);
        check("restart_b_hv", {21'(b_h), 11'(b_v)}, 0);
        check("restart_b_ad_fc", {b_ad, b_fc}, {1'b1, 6'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Generates raster timing for the pixel pipeline: horizontal/vertical pixel counters, sync pulses, active-draw flag, new-frame strobe and frame counter.
- Sits directly upstream of the sprite/compositing stages, which consume hcount_out/vcount_out.
- Also provides copies of hs/vs/ad delayed by a fixed number of cycles. These realign syncs with pixel data after the downstream memory lookups (two 2-cycle BRAMs, 4 cycles total).

Parameters:
- ACTIVE_H, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BACK, 220, horizontal back porch (pixels)
- ACTIVE_V, 720, active lines per frame
- V_FRONT, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BACK, 20, vertical back porch (lines)
- FPS, 60, frame counter modulus
- DELAY, 4, pipeline delay (cycles) for the *_dly_out copies; 0 = no delay

Ports:
- pixel_clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_out  output  11  horizontal pixel index, 0..TOTAL_H-1
- vcount_out  output  10  line index, 0..TOTAL_V-1
- hs_out  output  1  horizontal sync, active high
- vs_out  output  1  vertical sync, active high
- ad_out  output  1  active draw
- nf_out  output  1  new-frame strobe, one cycle
- fc_out  output  6  frame count, 0..FPS-1
- hs_dly_out  output  1  hs_out delayed DELAY cycles
- vs_dly_out  output  1  vs_out delayed DELAY cycles
- ad_dly_out  output  1  ad_out delayed DELAY cycles

Behaviour:
- Derived constants: TOTAL_H = ACTIVE_H+H_FRONT+H_SYNC+H_BACK (1650); TOTAL_V = ACTIVE_V+V_FRONT+V_SYNC+V_BACK (750).
- Reset is asynchronous, active low. While rst_n_in=0:
  - hcount_out=TOTAL_H-1, vcount_out=TOTAL_V-1 (last pixel of a frame, inside blanking).
  - hs_out=vs_out=ad_out=nf_out=0, fc_out=0.
  - All delay-line stages 0.
- Counters:
  - Every rising edge with rst_n_in=1: hcount increments.
  - At hcount=TOTAL_H-1, hcount wraps to 0 and vcount increments.
  - At (TOTAL_H-1, TOTAL_V-1), both wrap to 0.
  - First edge after reset release therefore presents (0,0).
- Flags are registers loaded from a decode of the next counter values, so each flag is exactly aligned with the hcount_out/vcount_out it describes (zero relative latency):
  - ad_out=1 iff hcount<ACTIVE_H and vcount<ACTIVE_V.
  - hs_out=1 iff ACTIVE_H+H_FRONT <= hcount < ACTIVE_H+H_FRONT+H_SYNC (1390..1429), on every line including vertical blanking.
  - vs_out=1 iff ACTIVE_V+V_FRONT <= vcount < ACTIVE_V+V_FRONT+V_SYNC (725..729), for all hcount on those lines.
  - nf_out=1 for exactly one cycle, when (hcount,vcount)=(ACTIVE_H, ACTIVE_V), i.e. (1280,720), the first blanking pixel after the last active pixel.
- fc_out:
  - Increments on the same edge that asserts nf_out, so it is visible together with nf_out.
  - Wraps FPS-1 -> 0.
- Delay lines:
  - DELAY-stage shift registers on hs/vs/ad: x_dly_out(t) = x_out(t-DELAY).
  - For DELAY=0, x_dly_out = x_out.
  - After reset release, *_dly_out stay 0 for DELAY cycles, then follow.
- Reset mid-frame: all state returns immediately (asynchronously) to the reset values; the next frame restarts at (0,0) after release.
- Widths: hcount is 11 bits and vcount is 10 bits, which covers the defaults. Parameters with TOTAL_H>2048 or TOTAL_V>1024 are unsupported.

Test Plan:
- Reset then release → first post-release edge gives hcount=0, vcount=0, ad=1, hs=0, vs=0, nf=0, fc=0. Sequence 0,1,2,… confirmed for 20 cycles.
- Line wrap → hcount 1649 followed by 0 with vcount incremented. hs high exactly cycles with hcount 1390..1429 (40 cycles/line). ad falls at hcount=1280.
- Frame wrap → at (1649,749) the next is (0,0). vs high only on lines 725..729 (5×1650 = 8250 cycles). Each frame is 1,237,500 cycles.
- nf/fc → nf pulses once per frame at (1280,720). fc steps 0,1,…,59,0 across 61 frames, changing in the nf cycle.
- Delay alignment, DELAY=4 → hs_dly/vs_dly/ad_dly equal hs/vs/ad from 4 cycles earlier. All 0 for the first 4 cycles after release. Also rerun with DELAY=0 (outputs identical to undelayed).
- Async reset at (500,300) mid-edge → outputs go to reset values before the next clock edge. Restart at (0,0), fc=0 after release.
